// File: rtl/key_expansion.sv
// AES-128 key-schedule controller: walks the external G block through rounds 1..10
// and streams round keys 0..10 out of a single 128-bit key register.
module key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         g_enable,
    output logic [31:0]  g_inputVal,
    output logic [3:0]   g_roundNum,
    input  logic [31:0]  g_outputVal,
    input  logic         g_done,
    output logic [127:0] round_key,
    output logic [3:0]   round_key_num,
    output logic         round_key_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] key_q, key_d;
    logic [127:0] key_step;
    logic [31:0]  chain;

    // Next round key: each new word is the old word XORed with the new word before it,
    // seeded by G's result for w0.
    always_comb begin
        key_step = '0;
        chain    = g_outputVal;
        for (int i = 0; i < 4; i++) begin
            chain                      = key_q[127-32*i -: 32] ^ chain;
            key_step[127-32*i -: 32]   = chain;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    rnd_d   = 4'd0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (rnd_q == LAST_ROUND) begin
                    state_d = S_DONE;
                end else begin
                    rnd_d   = rnd_q + 4'd1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            // One dead cycle so a done left over from the previous request is never taken.
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (g_done) begin
                    key_d   = key_step;
                    state_d = S_EMIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
        end
    end

    // The key register only changes on start or the WAIT exit edge, so the G request
    // words stay stable for the whole handshake without extra holding flops.
    assign g_enable        = (state_q == S_ISSUE);
    assign g_inputVal      = key_q[31:0];
    assign g_roundNum      = rnd_q;
    assign round_key       = key_q;
    assign round_key_num   = rnd_q;
    assign round_key_valid = (state_q == S_EMIT);
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_key_expansion.sv
// Randomized self-checking bench for key_expansion, with a behavioural G block and a
// FIPS-197 style key-schedule reference model.
module tb_key_expansion;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         g_enable;
    logic [31:0]  g_inputVal;
    logic [3:0]   g_roundNum;
    logic [31:0]  g_outputVal;
    logic         g_done;
    logic [127:0] round_key;
    logic [3:0]   round_key_num;
    logic         round_key_valid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    key_expansion dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .key_in          (key_in),
        .g_enable        (g_enable),
        .g_inputVal      (g_inputVal),
        .g_roundNum      (g_roundNum),
        .g_outputVal     (g_outputVal),
        .g_done          (g_done),
        .round_key       (round_key),
        .round_key_num   (round_key_num),
        .round_key_valid (round_key_valid),
        .busy            (busy),
        .done            (done)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sbox [256];
    logic [127:0] exp_rk [11];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ 8'h63;
            r = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox[a] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] c = 8'h01;
        for (int i = 1; i < r; i++) c = xtime(c);
        return c;
    endfunction

    function automatic logic [31:0] g_func(input logic [31:0] x, input int r);
        return sub_word({x[23:0], x[31:24]}) ^ {rcon(r), 24'h0};
    endfunction

    task automatic build_schedule(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = g_func(t, i / 4);
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- behavioural G block ----------------
    int         g_lat     = 1;
    bit         g_level   = 1'b0;
    bit         g_stale   = 1'b0;
    int         g_req_cnt = 0;
    logic [31:0] first_in;
    logic [3:0]  first_rnd;

    initial begin
        logic [31:0] req_in;
        logic [3:0]  req_rnd;
        g_done      = 1'b0;
        g_outputVal = 32'h0;
        forever begin
            @(negedge clk);
            if (g_enable && !rst) begin
                req_in  = g_inputVal;
                req_rnd = g_roundNum;
                if (g_req_cnt < 10) begin
                    chk("g_roundNum", 128'(req_rnd), 128'(g_req_cnt + 1));
                    chk("g_inputVal", 128'(req_in), 128'(exp_rk[g_req_cnt][31:0]));
                end
                if (g_req_cnt == 0) begin
                    first_in  = req_in;
                    first_rnd = req_rnd;
                end
                g_req_cnt++;
                @(posedge clk);
                if (g_stale) begin
                    #1 g_done = 1'b1;
                    g_outputVal = $urandom;
                    @(posedge clk);
                    #1 g_done = 1'b0;
                    repeat (g_lat - 1) @(posedge clk);
                end else begin
                    repeat (g_lat) @(posedge clk);
                end
                #1 g_done = 1'b1;
                g_outputVal = g_func(req_in, int'(req_rnd));
                @(negedge clk);
                if (busy) begin
                    chk("g_hold_in", 128'(g_inputVal), 128'(req_in));
                    chk("g_hold_rnd", 128'(g_roundNum), 128'(req_rnd));
                    chk("g_enable_pulse", 128'(g_enable), 128'(0));
                end
                @(posedge clk);
                if (g_level) @(posedge clk);
                #1 g_done = 1'b0;
                g_outputVal = $urandom;
            end
        end
    end

    // ---------------- run one expansion ----------------
    logic [127:0] got_rk [$];
    logic [3:0]   got_num [$];
    int           done_cnt;
    int           done_cyc;

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_round_key"}, round_key, 128'(0));
        chk({pfx, "_round_key_num"}, 128'(round_key_num), 128'(0));
        chk({pfx, "_valid"}, 128'(round_key_valid), 128'(0));
        chk({pfx, "_g_enable"}, 128'(g_enable), 128'(0));
        chk({pfx, "_g_inputVal"}, 128'(g_inputVal), 128'(0));
        chk({pfx, "_g_roundNum"}, 128'(g_roundNum), 128'(0));
        chk({pfx, "_busy"}, 128'(busy), 128'(0));
        chk({pfx, "_done"}, 128'(done), 128'(0));
    endtask

    task automatic run_key(input logic [127:0] key, input int lat, input bit level,
                           input bit stale, input int start_at, input int rst_at);
        int cyc;
        bit fin;
        bit did_rst;
        int n_before;
        build_schedule(key);
        g_lat     = lat;
        g_level   = level;
        g_stale   = stale;
        g_req_cnt = 0;
        got_rk.delete();
        got_num.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        did_rst   = 1'b0;
        @(negedge clk);
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        chk("start_latency", 128'(round_key_valid), 128'(1));
        cyc = 0;
        fin = 1'b0;
        while (!fin && cyc < 1000) begin
            start = 1'b0;
            if (round_key_valid) begin
                got_rk.push_back(round_key);
                got_num.push_back(round_key_num);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy) begin
                fin = 1'b1;
            end else if (round_key_valid && int'(round_key_num) == start_at) begin
                start  = 1'b1;
                key_in = ~key;
            end else if (round_key_valid && int'(round_key_num) == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                check_reset_outputs("rst_mid");
                n_before = got_rk.size();
                repeat (40) begin
                    @(negedge clk);
                    if (round_key_valid) got_rk.push_back(round_key);
                    if (done) done_cnt++;
                end
                chk("rst_no_valid", 128'(got_rk.size()), 128'(n_before));
                chk("rst_no_done", 128'(done_cnt), 128'(0));
                did_rst = 1'b1;
                fin     = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("finish_in_budget", 128'(fin), 128'(1));
        if (did_rst) begin
            chk("rst_keys_before", 128'(got_rk.size()), 128'(rst_at + 1));
            for (int i = 0; i < got_rk.size() && i <= rst_at; i++)
                chk($sformatf("rst_rk%0d", i), got_rk[i], exp_rk[i]);
        end else begin
            chk("n_keys", 128'(got_rk.size()), 128'(11));
            for (int i = 0; i < got_rk.size() && i < 11; i++) begin
                chk($sformatf("rk_num%0d", i), 128'(got_num[i]), 128'(i));
                chk($sformatf("rk%0d", i), got_rk[i], exp_rk[i]);
            end
            chk("done_count", 128'(done_cnt), 128'(1));
            chk("done_cycle", 128'(done_cyc), 128'(1 + 10 * (3 + lat)));
            chk("retain_rk10", round_key, exp_rk[10]);
            chk("g_requests", 128'(g_req_cnt), 128'(10));
        end
        $display("run key=%h L=%0d level=%0d stale=%0d keys=%0d done=%0d",
                 key, lat, level, stale, got_rk.size(), done_cnt);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [127:0] fips_ref [11];
        build_sbox();
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_key(FIPS_KEY, 1, 1'b0, 1'b0, -1, -1);
        chk("fips_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("first_g_in", 128'(first_in), 128'(32'h09cf4f3c));
        chk("first_g_rnd", 128'(first_rnd), 128'(1));
        for (int i = 0; i < 11; i++) fips_ref[i] = got_rk[i];

        run_key(FIPS_KEY, 12, 1'b0, 1'b1, -1, -1);
        for (int i = 0; i < 11; i++) chk($sformatf("lat12_vs_lat1_rk%0d", i), got_rk[i], fips_ref[i]);

        run_key(128'h0, 3, 1'b0, 1'b0, -1, -1);
        chk("zero_r0", got_rk[0], 128'h0);
        chk("zero_r1", got_rk[1], 128'h62636363626363636263636362636363);
        chk("zero_r10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        run_key(FIPS_KEY, 2, 1'b0, 1'b0, 4, -1);
        run_key(FIPS_KEY, 4, 1'b0, 1'b0, -1, 5);
        run_key(128'h0, 1, 1'b0, 1'b0, -1, -1);
        run_key({$urandom, $urandom, $urandom, $urandom}, 2, 1'b1, 1'b0, -1, -1);
        repeat (4) begin
            run_key({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(1, 6)),
                    1'($urandom_range(0, 1)), 1'b0, -1, -1);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_expansion.md
# key_expansion

AES-128 key-schedule controller. It accepts a 128-bit cipher key and drives the existing G (RotWord/SubWord/Rcon) block one round at a time through a request/done handshake. From G's result it computes the remaining three words of each round key and streams all 11 round keys (rounds 0..10) to the cipher datapath, one per `round_key_valid` pulse. The block sits directly upstream of G, which it feeds and whose output it consumes.

## Interface
- Parameters: none; AES-128 only.
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request expansion; honoured only in IDLE.
- key_in  in  128  cipher key, sampled when start is accepted; [127:96]=w0 … [31:0]=w3.
- g_enable  out  1  one-cycle request pulse to G.
- g_inputVal  out  32  word sent to G; always the current w3.
- g_roundNum  out  4  round number sent to G, range 1..10.
- g_outputVal  in  32  G result.
- g_done  in  1  G result valid.
- round_key  out  128  current round key, same word order as key_in.
- round_key_num  out  4  index of round_key, range 0..10.
- round_key_valid  out  1  one-cycle pulse; round_key and round_key_num are valid during it.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after round 10 is emitted.

## Operation
- States: IDLE, EMIT, ISSUE, GUARD, WAIT, DONE.
- IDLE:
  - start=1 loads key_in into the key register and sets rnd=0.
  - Then goes to EMIT.
- EMIT:
  - round_key_valid=1.
  - If rnd==10, go to DONE.
  - Otherwise rnd←rnd+1 and go to ISSUE.
- ISSUE:
  - g_enable=1 for exactly one cycle.
  - g_inputVal=w3, g_roundNum=rnd.
  - Then goes to GUARD.
- GUARD:
  - Lasts one cycle and ignores g_done, which discards any stale done from the previous request.
  - Then goes to WAIT.
- WAIT:
  - Holds until g_done=1.
  - On that edge, registers w0'=w0^g_outputVal, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - Then goes to EMIT.
- DONE:
  - done=1 for one cycle.
  - Then goes to IDLE.
- g_inputVal and g_roundNum are held stable from ISSUE until the WAIT exit edge.
- The XOR chain is combinational from g_outputVal. No arithmetic carries; all operations are 32-bit XOR.
- round_key is always the key register. It retains the round-10 key after completion until the next accepted start.

## Timing
- Reset values:
  - state=IDLE, rnd=0.
  - round_key=0, round_key_num=0.
  - round_key_valid=0, g_enable=0, g_inputVal=0, g_roundNum=0.
  - busy=0, done=0.
- Start latency: start sampled at edge k gives the round-0 valid pulse during cycle k+1.
- Round period: 3+L cycles, where L = cycles from the edge that samples g_enable to the first g_done (L≥1). Total expansion time = 1+10·(3+L)+1 cycles.
- Boundary conditions:
  - start while busy (including in DONE): ignored; key_in is not re-sampled.
  - rst asserted in any state: IDLE on the next edge with all outputs at reset values. A late g_done arriving in IDLE is ignored.
  - g_done held as a level: the WAIT state captures only once, because the state leaves WAIT on the capture edge.
  - g_done high during ISSUE or GUARD: ignored.

## Test plan
- Reset check: assert rst for 2 cycles mid-activity -> every output is 0 and busy=0 on the following cycle.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> exactly 11 valid pulses with round_key_num 0..10, plus one done pulse after round 10:
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
- All-zero key ->
  - round 0 = 0
  - round 1 = 62636363626363636263636362636363
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e
- Handshake, using the FIPS key with G replaced by a bench model of latency L=1 and then L=12:
  - First g_enable carries g_inputVal=09cf4f3c and g_roundNum=1.
  - Both values are held until g_done.
  - g_enable is a single-cycle pulse.
  - A g_done forced high during GUARD is ignored.
  - Round-key values are identical for both latencies.
- Control corners:
  - start pulsed at round 4 -> ignored; the sequence completes unchanged.
  - rst at round 5 -> IDLE, and no further valid pulses occur.
  - Restart with the zero key -> the correct round 0..10 sequence.
